// File: rtl/hazard_ctrl_seq.sv
// Hazard controller beside the ID/EX datapath: N-deep operand forwarding plus
// multi-cycle load-use stall and branch flush sequenced by a small FSM.
module hazard_ctrl_seq #(
    parameter int REG_W      = 5,
    parameter int FWD_STAGES = 2,
    parameter int LOAD_LAT   = 1,
    parameter int BR_FLUSH   = 1,
    parameter int CNT_W      = 16,
    localparam int SEL_W     = $clog2(FWD_STAGES + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [REG_W-1:0]            rs_d,
    input  logic [REG_W-1:0]            rt_d,
    input  logic [REG_W-1:0]            rs_e,
    input  logic [REG_W-1:0]            rt_e,
    input  logic [REG_W-1:0]            dst_e,
    input  logic                        load_e,
    input  logic [FWD_STAGES*REG_W-1:0] dst_vec,
    input  logic [FWD_STAGES-1:0]       wr_vec,
    input  logic                        branch_taken_e,
    input  logic                        ext_stall,
    output logic [SEL_W-1:0]            fwd_a,
    output logic [SEL_W-1:0]            fwd_b,
    output logic                        stall_f,
    output logic                        stall_d,
    output logic                        flush_d,
    output logic                        flush_e,
    output logic                        busy,
    output logic [CNT_W-1:0]            stall_cycles
);
    localparam int CNT_MAX = ((LOAD_LAT > BR_FLUSH) ? LOAD_LAT : BR_FLUSH) - 1;
    localparam int CW      = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

    typedef enum logic [1:0] {IDLE, LSTALL, BFLUSH} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [CNT_W-1:0] stall_cnt;
    logic [FWD_STAGES-1:0] match_a, match_b;
    logic [SEL_W-1:0] fa_raw, fb_raw;
    logic sf, sd, fd, fe;
    logic lhz, bhz;

    // Per-stage comparators; r0 is hard-wired zero and never forwarded.
    for (genvar k = 0; k < FWD_STAGES; k++) begin : g_match
        assign match_a[k] = wr_vec[k] && (dst_vec[k*REG_W +: REG_W] == rs_e) && (rs_e != '0);
        assign match_b[k] = wr_vec[k] && (dst_vec[k*REG_W +: REG_W] == rt_e) && (rt_e != '0);
    end

    // Scan oldest to youngest so the youngest matching stage is the last writer.
    always_comb begin
        fa_raw = '0;
        fb_raw = '0;
        for (int k = FWD_STAGES; k >= 1; k--) begin
            if (match_a[k-1]) fa_raw = SEL_W'(k);
            if (match_b[k-1]) fb_raw = SEL_W'(k);
        end
    end

    assign lhz = load_e && (dst_e != '0) && ((dst_e == rs_d) || (dst_e == rt_d));
    assign bhz = branch_taken_e;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sf      = 1'b0;
        sd      = 1'b0;
        fd      = 1'b0;
        fe      = 1'b0;
        if (!ext_stall) begin
            unique case (state)
                IDLE, LSTALL: begin
                    if (bhz) begin
                        // A taken branch squashes whatever the load stall was protecting.
                        fd = 1'b1;
                        fe = 1'b1;
                        if (BR_FLUSH > 1) begin
                            state_n = BFLUSH;
                            cnt_n   = CW'(BR_FLUSH - 2);
                        end else begin
                            state_n = IDLE;
                        end
                    end else if (state == LSTALL) begin
                        sf = 1'b1;
                        sd = 1'b1;
                        fe = 1'b1;
                        if (cnt == '0) state_n = IDLE;
                        else           cnt_n   = cnt - CW'(1);
                    end else if (lhz) begin
                        sf = 1'b1;
                        sd = 1'b1;
                        fe = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_n = LSTALL;
                            cnt_n   = CW'(LOAD_LAT - 2);
                        end
                    end
                end
                BFLUSH: begin
                    fd = 1'b1;
                    fe = 1'b1;
                    if (cnt == '0) state_n = IDLE;
                    else           cnt_n   = cnt - CW'(1);
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (sf && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // Everything reads as zero while reset is held, forwarding included.
    assign fwd_a        = reset ? '0 : fa_raw;
    assign fwd_b        = reset ? '0 : fb_raw;
    assign stall_f      = !reset && sf;
    assign stall_d      = !reset && sd;
    assign flush_d      = !reset && fd;
    assign flush_e      = !reset && fe;
    assign busy         = !reset && (state != IDLE);
    assign stall_cycles = reset ? '0 : stall_cnt;
endmodule

// File: tb/tb_hazard_ctrl_seq.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a negedge
// monitor pops one per cycle and compares against the selected instance.
module tb_hazard_ctrl_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    logic [4:0] rs_d, rt_d, rs_e, rt_e, dst_e;
    logic load_e, branch_taken_e, ext_stall;
    logic [9:0] dst_vec;
    logic [1:0] wr_vec;

    logic [1:0] fa_a, fb_a, fa_b, fb_b;
    logic sf_a, sd_a, fd_a, fe_a, bz_a, sf_b, sd_b, fd_b, fe_b, bz_b;
    logic [15:0] sc_a;
    logic [1:0]  sc_b;

    hazard_ctrl_seq #(.REG_W(5), .FWD_STAGES(2), .LOAD_LAT(3), .BR_FLUSH(2), .CNT_W(16)) dut_a (
        .clk(clk), .reset(rst_a), .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
        .dst_e(dst_e), .load_e(load_e), .dst_vec(dst_vec), .wr_vec(wr_vec),
        .branch_taken_e(branch_taken_e), .ext_stall(ext_stall),
        .fwd_a(fa_a), .fwd_b(fb_a), .stall_f(sf_a), .stall_d(sd_a), .flush_d(fd_a),
        .flush_e(fe_a), .busy(bz_a), .stall_cycles(sc_a));

    hazard_ctrl_seq #(.REG_W(5), .FWD_STAGES(2), .LOAD_LAT(1), .BR_FLUSH(1), .CNT_W(2)) dut_b (
        .clk(clk), .reset(rst_b), .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
        .dst_e(dst_e), .load_e(load_e), .dst_vec(dst_vec), .wr_vec(wr_vec),
        .branch_taken_e(branch_taken_e), .ext_stall(ext_stall),
        .fwd_a(fa_b), .fwd_b(fb_b), .stall_f(sf_b), .stall_d(sd_b), .flush_d(fd_b),
        .flush_e(fe_b), .busy(bz_b), .stall_cycles(sc_b));

    typedef struct {
        string    nm;
        bit       which;
        int       fa, fb;
        bit       sf, sd, fd, fe, bz;
        int       sc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    // Monitor: one expectation per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            int afa, afb, asc;
            bit asf, asd, afd, afe, abz;
            e = q.pop_front();
            if (e.which) begin
                afa = int'(fa_b); afb = int'(fb_b); asf = sf_b; asd = sd_b;
                afd = fd_b; afe = fe_b; abz = bz_b; asc = int'(sc_b);
            end else begin
                afa = int'(fa_a); afb = int'(fb_a); asf = sf_a; asd = sd_a;
                afd = fd_a; afe = fe_a; abz = bz_a; asc = int'(sc_a);
            end
            checks++;
            if (afa != e.fa || afb != e.fb || asf != e.sf || asd != e.sd || afd != e.fd ||
                afe != e.fe || abz != e.bz || asc != e.sc) begin
                failures++;
                $display("FAIL %s: got fa=%0d fb=%0d sf=%0d sd=%0d fd=%0d fe=%0d busy=%0d sc=%0d, want fa=%0d fb=%0d sf=%0d sd=%0d fd=%0d fe=%0d busy=%0d sc=%0d",
                         e.nm, afa, afb, asf, asd, afd, afe, abz, asc,
                         e.fa, e.fb, e.sf, e.sd, e.fd, e.fe, e.bz, e.sc);
            end
        end
    end

    task automatic chk(input string nm, input bit which, input int fa, input int fb,
                       input bit sf, input bit sd, input bit fd, input bit fe,
                       input bit bz, input int sc);
        exp_t e;
        e.nm = nm; e.which = which; e.fa = fa; e.fb = fb; e.sf = sf; e.sd = sd;
        e.fd = fd; e.fe = fe; e.bz = bz; e.sc = sc;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rs_d = '0; rt_d = '0; rs_e = '0; rt_e = '0; dst_e = '0;
        load_e = 1'b0; branch_taken_e = 1'b0; ext_stall = 1'b0;
        dst_vec = '0; wr_vec = '0;
    endtask

    task automatic load7();
        load_e = 1'b1; dst_e = 5'd7; rt_d = 5'd7;
    endtask

    initial begin
        int guard;
        clr();
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset forces zero even with a live forwarding match.
        wr_vec = 2'b11; dst_vec = {5'd3, 5'd3}; rs_e = 5'd3;
        chk("reset_zero", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_a = 1'b0;
        chk("fwd_mem_wins", 0, 1, 0, 0, 0, 0, 0, 0, 0);
        wr_vec = 2'b10;
        chk("fwd_wb_only", 0, 2, 0, 0, 0, 0, 0, 0, 0);
        wr_vec = 2'b11; dst_vec = {5'd3, 5'd9}; rt_e = 5'd9;
        chk("fwd_a_wb_b_mem", 0, 2, 1, 0, 0, 0, 0, 0, 0);
        rs_e = '0; rt_e = '0; dst_vec = '0;
        chk("fwd_r0", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        clr();

        // Three-cycle load-use stall.
        load7();
        chk("ld_c1", 0, 0, 0, 1, 1, 0, 1, 0, 0);
        clr();
        chk("ld_c2", 0, 0, 0, 1, 1, 0, 1, 1, 1);
        chk("ld_c3", 0, 0, 0, 1, 1, 0, 1, 1, 2);
        chk("ld_done", 0, 0, 0, 0, 0, 0, 0, 0, 3);

        // Branch in second stall cycle takes over.
        load7();
        chk("lb_c1", 0, 0, 0, 1, 1, 0, 1, 0, 3);
        clr(); branch_taken_e = 1'b1;
        chk("lb_branch", 0, 0, 0, 0, 0, 1, 1, 1, 4);
        clr();
        chk("lb_bflush", 0, 0, 0, 0, 0, 1, 1, 1, 4);
        chk("lb_idle", 0, 0, 0, 0, 0, 0, 0, 0, 4);

        // Freeze mid-stall; forwarding keeps working underneath.
        load7();
        chk("ext_c1", 0, 0, 0, 1, 1, 0, 1, 0, 4);
        clr(); ext_stall = 1'b1; wr_vec = 2'b01; dst_vec = {5'd0, 5'd4}; rs_e = 5'd4;
        for (int i = 0; i < 4; i++) chk("ext_frozen", 0, 1, 0, 0, 0, 0, 0, 1, 5);
        clr();
        chk("ext_resume1", 0, 0, 0, 1, 1, 0, 1, 1, 5);
        chk("ext_resume2", 0, 0, 0, 1, 1, 0, 1, 1, 6);
        chk("ext_idle", 0, 0, 0, 0, 0, 0, 0, 0, 7);

        // Branch beats load in IDLE; BFLUSH ignores a lingering load hazard.
        load_e = 1'b1; dst_e = 5'd7; rs_d = 5'd7; branch_taken_e = 1'b1;
        chk("prio_branch", 0, 0, 0, 0, 0, 1, 1, 0, 7);
        branch_taken_e = 1'b0;
        chk("bflush_ign_lhz", 0, 0, 0, 0, 0, 1, 1, 1, 7);
        clr();
        chk("prio_idle", 0, 0, 0, 0, 0, 0, 0, 0, 7);
        load_e = 1'b1; dst_e = '0; rs_d = '0;
        chk("load_r0", 0, 0, 0, 0, 0, 0, 0, 0, 7);
        clr();

        // Reset in the middle of LSTALL.
        load7();
        chk("rst_ld_c1", 0, 0, 0, 1, 1, 0, 1, 0, 7);
        clr(); rst_a = 1'b1;
        chk("rst_mid", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_a = 1'b0;
        chk("rst_after", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Narrow counter, single-cycle stalls.
        rst_a = 1'b1; rst_b = 1'b0;
        chk("b_reset", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            load7();
            chk("b_ld", 1, 0, 0, 1, 1, 0, 1, 0, (i < 3) ? i : 3);
            clr();
            chk("b_sat", 1, 0, 0, 0, 0, 0, 0, 0, (i + 1 < 3) ? i + 1 : 3);
        end
        branch_taken_e = 1'b1;
        chk("b_branch1", 1, 0, 0, 0, 0, 1, 1, 0, 3);
        clr();
        chk("b_branch_idle", 1, 0, 0, 0, 0, 0, 0, 0, 3);

        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
